// File: rtl/psi_dma_arbiter_pkg.sv
// Shared types for the psi DMA arbiter: FSM state encoding.
package psi_dma_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_WGNT = 2'd1,
    ARB_XFER = 2'd2,
    ARB_GAP  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/psi_dma_arbiter_rr_pick.sv
// Rotate-priority encoder: first set request at or after ptr, wrapping.
module psi_rr_pick #(
  parameter  int unsigned NREQ = 4,
  localparam int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   index,
  output logic            any
);

  int unsigned idx;

  always_comb begin
    onehot = '0;
    index  = '0;
    idx    = 0;
    any    = |req;
    // Scan from the farthest slot back towards ptr so the nearest hit is written last.
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + NREQ - 1 - k) % NREQ;
      if (req[idx]) begin
        onehot      = '0;
        onehot[idx] = 1'b1;
        index       = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/psi_dma_arbiter.sv
// Round-robin arbiter sharing the psi parallel port among NREQ DMA requesters.
module psi_dma_arbiter
  import psi_dma_arbiter_pkg::*;
#(
  parameter  int unsigned DSIZE    = 32,
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned MAX_PKTS = 4,
  parameter  int unsigned GAP_CYC  = 2,
  localparam int unsigned IW       = $clog2(NREQ)
) (
  input  logic                  p_clk,
  input  logic                  n_rst,
  input  logic [NREQ-1:0]       m_req,
  input  logic [NREQ*DSIZE-1:0] m_data,
  input  logic [NREQ-1:0]       m_pkt_end,
  output logic [NREQ-1:0]       m_grant,
  output logic [NREQ-1:0]       m_ready,
  output logic                  psi_req,
  input  logic                  psi_grant,
  input  logic                  psi_ready,
  output logic [DSIZE-1:0]      psi_data,
  output logic                  psi_pkt_end,
  output logic [IW-1:0]         owner,
  output logic                  busy,
  output logic                  proto_err
);

  localparam int unsigned CW = $clog2(MAX_PKTS + 1);
  localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  arb_state_e      state, state_nxt;
  logic [IW-1:0]   owner_q, owner_nxt, rr_ptr, rr_nxt;
  logic [NREQ-1:0] own_oh, own_oh_nxt;
  logic [CW-1:0]   pkt_cnt, pkt_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            in_pkt, in_pkt_nxt, err_nxt;
  logic            try_pick, leave;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            own_req, own_end, others, beat;

  psi_rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (m_req),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .index  (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    own_req = m_req[owner_q];
    own_end = m_pkt_end[owner_q];
    others  = |(m_req & ~own_oh);
    beat    = (state == ARB_XFER) && psi_grant && psi_ready && own_req;

    state_nxt   = state;
    owner_nxt   = owner_q;
    own_oh_nxt  = own_oh;
    rr_nxt      = rr_ptr;
    pkt_cnt_nxt = pkt_cnt;
    gap_cnt_nxt = gap_cnt;
    in_pkt_nxt  = in_pkt;
    err_nxt     = 1'b0;
    try_pick    = 1'b0;
    leave       = 1'b0;

    case (state)
      ARB_IDLE: try_pick = 1'b1;
      ARB_WGNT: begin
        if (!own_req)       leave     = 1'b1;
        else if (psi_grant) state_nxt = ARB_XFER;
      end
      ARB_XFER: begin
        if (!psi_grant) begin
          leave   = 1'b1;
          err_nxt = 1'b1;
        end else if (!own_req) begin
          leave   = 1'b1;
          err_nxt = in_pkt;
        end else if (beat) begin
          if (own_end) begin
            in_pkt_nxt = 1'b0;
            if (pkt_cnt != CW'(MAX_PKTS)) pkt_cnt_nxt = pkt_cnt + CW'(1);
            if ((pkt_cnt_nxt == CW'(MAX_PKTS)) && others) leave = 1'b1;
          end else begin
            in_pkt_nxt = 1'b1;
          end
        end
      end
      ARB_GAP: begin
        // The last gap cycle doubles as the pick cycle so psi_req stays low exactly GAP_CYC cycles.
        if (gap_cnt == '0) begin
          state_nxt = ARB_IDLE;
          try_pick  = 1'b1;
        end else begin
          gap_cnt_nxt = gap_cnt - GW'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase

    if (try_pick && pick_any) begin
      state_nxt  = ARB_WGNT;
      owner_nxt  = pick_idx;
      own_oh_nxt = pick_oh;
    end

    if (leave) begin
      state_nxt   = ARB_GAP;
      gap_cnt_nxt = GW'(GAP_CYC - 1);
      rr_nxt      = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
      pkt_cnt_nxt = '0;
      in_pkt_nxt  = 1'b0;
    end
  end

  always_ff @(posedge p_clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= ARB_IDLE;
      owner_q   <= '0;
      own_oh    <= '0;
      rr_ptr    <= '0;
      pkt_cnt   <= '0;
      gap_cnt   <= '0;
      in_pkt    <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      owner_q   <= owner_nxt;
      own_oh    <= own_oh_nxt;
      rr_ptr    <= rr_nxt;
      pkt_cnt   <= pkt_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      in_pkt    <= in_pkt_nxt;
      proto_err <= err_nxt;
    end
  end

  always_comb begin
    psi_req     = (state == ARB_WGNT) || (state == ARB_XFER);
    m_grant     = psi_req ? own_oh : '0;
    m_ready     = ((state == ARB_XFER) && psi_ready && psi_grant) ? own_oh : '0;
    psi_data    = (state == ARB_XFER) ? m_data[owner_q*DSIZE +: DSIZE] : '0;
    psi_pkt_end = (state == ARB_XFER) && own_end;
    owner       = owner_q;
    busy        = (state != ARB_IDLE);
  end

endmodule

// File: tb/tb_psi_dma_arbiter.sv
// Randomized bench for psi_dma_arbiter: behavioural requesters, psi model and transaction-rule reference.
module tb_psi_dma_arbiter;

  localparam int unsigned DSIZE    = 32;
  localparam int unsigned NREQ     = 4;
  localparam int unsigned MAX_PKTS = 4;
  localparam int unsigned GAP_CYC  = 2;
  localparam int unsigned IW       = 2;
  localparam int unsigned LIMIT    = 3000;

  logic                  p_clk = 1'b0;
  logic                  n_rst = 1'b1;
  logic [NREQ-1:0]       m_req = '0;
  logic [NREQ*DSIZE-1:0] m_data = '0;
  logic [NREQ-1:0]       m_pkt_end = '0;
  logic [NREQ-1:0]       m_grant, m_ready;
  logic                  psi_req, psi_pkt_end, busy, proto_err;
  logic                  psi_grant = 1'b0;
  logic                  psi_ready = 1'b0;
  logic [DSIZE-1:0]      psi_data;
  logic [IW-1:0]         owner;

  always #5 p_clk = ~p_clk;

  psi_dma_arbiter #(
    .DSIZE(DSIZE), .NREQ(NREQ), .MAX_PKTS(MAX_PKTS), .GAP_CYC(GAP_CYC)
  ) dut (
    .p_clk(p_clk), .n_rst(n_rst), .m_req(m_req), .m_data(m_data), .m_pkt_end(m_pkt_end),
    .m_grant(m_grant), .m_ready(m_ready), .psi_req(psi_req), .psi_grant(psi_grant),
    .psi_ready(psi_ready), .psi_data(psi_data), .psi_pkt_end(psi_pkt_end), .owner(owner),
    .busy(busy), .proto_err(proto_err)
  );

  int unsigned n_chk = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // requester agents
  int unsigned pkts_left[NREQ], plen[NREQ], widx[NREQ], seq[NREQ], beat_cnt[NREQ];
  int          abort_at[NREQ];
  int unsigned fix_len = 8, gdly = 0;
  bit          rand_mode = 0;

  // reference model
  bit          exp_act, exp_xfer, exp_err, exp_inpkt, prev_req;
  int unsigned exp_own, exp_rr, exp_pk, low_cnt, err_seen;
  int unsigned obs_own[$];

  function automatic logic [DSIZE-1:0] word_of(input int unsigned i, input int unsigned s);
    return {4'(i), 28'(s)};
  endfunction

  function automatic int unsigned new_len();
    return (fix_len != 0) ? fix_len : $urandom_range(1, 8);
  endfunction

  function automatic int unsigned rr_choose(input int unsigned ptr, input logic [NREQ-1:0] rq);
    for (int unsigned k = 0; k < NREQ; k++)
      if (rq[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return 0;
  endfunction

  function automatic bit work_left();
    for (int unsigned i = 0; i < NREQ; i++) if (pkts_left[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_inputs();
    for (int unsigned i = 0; i < NREQ; i++) begin
      m_req[i] = (pkts_left[i] != 0);
      m_data[i*DSIZE +: DSIZE] = m_req[i] ? word_of(i, seq[i]) : DSIZE'($urandom);
      m_pkt_end[i] = m_req[i] ? (widx[i] == plen[i] - 1) : 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset(input string tag);
    n_rst = 1'b0;
    #1;
    check_eq({tag, "_psi_req"}, psi_req, 0);
    check_eq({tag, "_m_grant"}, m_grant, 0);
    check_eq({tag, "_m_ready"}, m_ready, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_proto_err"}, proto_err, 0);
    check_eq({tag, "_psi_data"}, psi_data, 0);
    psi_grant = 1'b0;
    psi_ready = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      pkts_left[i] = 0; widx[i] = 0; beat_cnt[i] = 0; abort_at[i] = -1; plen[i] = new_len();
    end
    drive_inputs();
    exp_act = 0; exp_xfer = 0; exp_err = 0; exp_inpkt = 0; prev_req = 0;
    exp_own = 0; exp_rr = 0; exp_pk = 0; low_cnt = GAP_CYC + 1; err_seen = 0;
    obs_own.delete();
    repeat (2) @(negedge p_clk);
    n_rst = 1'b1;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic step();
    logic [NREQ-1:0] oh, rq, beats;
    bit end_t, err_n;
    oh = '0;
    if (exp_act) oh[exp_own] = 1'b1;
    check_eq("psi_req", psi_req, exp_act);
    check_eq("m_grant", m_grant, oh);
    check_eq("m_ready", m_ready, (exp_xfer && psi_ready && psi_grant) ? oh : '0);
    check_eq("busy", busy, exp_act || (low_cnt <= GAP_CYC));
    check_eq("proto_err", proto_err, exp_err);
    if (exp_act) check_eq("owner", owner, exp_own);
    if (exp_xfer && m_req[exp_own]) begin
      check_eq("psi_data", psi_data, word_of(exp_own, seq[exp_own]));
      check_eq("psi_pkt_end", psi_pkt_end, widx[exp_own] == plen[exp_own] - 1);
    end else if (!exp_xfer) begin
      check_eq("psi_data_idle", psi_data, 0);
      check_eq("psi_pkt_end_idle", psi_pkt_end, 0);
    end
    if (psi_req && !prev_req) obs_own.push_back(owner);
    prev_req = psi_req;
    if (proto_err) err_seen++;

    rq = m_req;
    err_n = 0;
    end_t = 0;
    if (exp_act) begin
      if (!exp_xfer) begin
        if (!rq[exp_own]) end_t = 1;
        else if (psi_grant) exp_xfer = 1;
      end else if (!psi_grant) begin
        end_t = 1; err_n = 1;
      end else if (!rq[exp_own]) begin
        end_t = 1; err_n = exp_inpkt;
      end else if (psi_ready) begin
        if (widx[exp_own] == plen[exp_own] - 1) begin
          exp_inpkt = 0;
          if (exp_pk < MAX_PKTS) exp_pk++;
          if (exp_pk >= MAX_PKTS && (rq & ~oh) != 0) end_t = 1;
        end else begin
          exp_inpkt = 1;
        end
      end
      if (end_t) begin
        exp_act = 0; exp_xfer = 0; exp_rr = (exp_own + 1) % NREQ;
        low_cnt = 1; exp_pk = 0; exp_inpkt = 0;
      end
    end else if (low_cnt >= GAP_CYC && rq != 0) begin
      exp_act = 1; exp_xfer = 0; exp_own = rr_choose(exp_rr, rq);
    end else if (low_cnt <= GAP_CYC) begin
      low_cnt++;
    end
    exp_err = err_n;

    beats = m_ready & m_req;
    @(posedge p_clk);
    #1;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (beats[i]) begin
        seq[i]++; widx[i]++; beat_cnt[i]++;
        if (widx[i] == plen[i]) begin
          widx[i] = 0; pkts_left[i]--; plen[i] = new_len();
        end else if (abort_at[i] >= 0 && widx[i] == 32'(abort_at[i])) begin
          widx[i] = 0; pkts_left[i] = 0; abort_at[i] = -1; plen[i] = new_len();
        end
      end
      if (rand_mode && pkts_left[i] == 0 && $urandom_range(0, 15) == 0) begin
        pkts_left[i] = $urandom_range(1, 6);
        if ($urandom_range(0, 7) == 0) abort_at[i] = int'($urandom_range(1, 7));
      end
    end
    if (!psi_req) begin
      psi_grant = 1'b0; gdly = $urandom_range(0, 3);
    end else if (gdly == 0) begin
      psi_grant = 1'b1;
    end else begin
      gdly--;
    end
    if (rand_mode && psi_req && $urandom_range(0, 199) == 0) psi_grant = 1'b0;
    psi_ready = ($urandom_range(0, 3) != 0);
    drive_inputs();
    @(negedge p_clk);
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    do begin
      step(); n++;
    end while (n < LIMIT && (work_left() || exp_act || low_cnt <= GAP_CYC));
    check_eq({tag, "_drain_in_time"}, n < LIMIT, 1);
  endtask

  task automatic check_order(input string tag, input int unsigned n, input int unsigned a0,
                             input int unsigned a1, input int unsigned a2, input int unsigned a3);
    int unsigned e[4];
    e = '{a0, a1, a2, a3};
    check_eq({tag, "_grants"}, obs_own.size(), n);
    for (int unsigned k = 0; k < n && k < obs_own.size(); k++)
      check_eq($sformatf("%s_grant%0d", tag, k), obs_own[k], e[k]);
  endtask

  initial begin
    int unsigned n;
    #3;
    for (int unsigned i = 0; i < NREQ; i++) seq[i] = 0;

    do_reset("t1_rst");
    pkts_left[0] = 2; drive_inputs();
    drain("t1");
    check_order("t1", 1, 0, 0, 0, 0);
    check_eq("t1_words", beat_cnt[0], 16);

    do_reset("t2_rst");
    for (int unsigned i = 0; i < NREQ; i++) pkts_left[i] = 1;
    drive_inputs();
    drain("t2");
    check_order("t2", 4, 0, 1, 2, 3);

    do_reset("t3_rst");
    pkts_left[1] = 10; pkts_left[2] = 2; drive_inputs();
    drain("t3");
    check_order("t3", 3, 1, 2, 1, 0);
    check_eq("t3_words_r1", beat_cnt[1], 80);

    do_reset("t4_rst");
    pkts_left[1] = 10; drive_inputs();
    drain("t4");
    check_order("t4", 1, 1, 0, 0, 0);

    do_reset("t5_rst");
    pkts_left[0] = 2; abort_at[0] = 3; pkts_left[1] = 1; drive_inputs();
    drain("t5");
    check_order("t5", 2, 0, 1, 0, 0);
    check_eq("t5_proto_err_pulses", err_seen, 1);
    check_eq("t5_words_r0", beat_cnt[0], 3);

    do_reset("rnd_rst");
    fix_len = 0; rand_mode = 1;
    repeat (LIMIT) step();
    rand_mode = 0;
    drain("rnd");

    fix_len = 8;
    do_reset("t6_rst");
    pkts_left[2] = 3; drive_inputs();
    n = 0;
    while (!exp_xfer && n < 100) begin step(); n++; end
    check_eq("t6_reach_xfer", exp_xfer, 1);
    #2;
    do_reset("t6_mid");
    pkts_left[3] = 1; drive_inputs();
    drain("t6");
    check_order("t6", 1, 3, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
